// File: rtl/uart_dev.sv
// UART with host bus: one TX holding register + shifter, RX with pending-byte storage.
// Latency: TX line goes low 2 cycles after the wrn rise; RX byte pending just after mid-stop sample.
// Backpressure: writes ignored while tbre=0 or rdn=0; RX bytes dropped (overrun) when storage is full.
//
// Ports: clk, rst (async active-low), data (16-bit host bus, driven only while rdn=0),
//        rdn/wrn (active-low strobes, act on rising edge), data_ready/tbre/tsre (status),
//        rxd/txd (serial), overrun/frame_err (sticky error flags).
// Build option: define UART_DEV_RX_FIFO_EN for a 4-entry RX FIFO; default is a single holding register.
module uart_dev #(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] data,
    input  logic        rdn,
    input  logic        wrn,
    output logic        data_ready,
    output logic        tbre,
    output logic        tsre,
    input  logic        rxd,
    output logic        txd,
    output logic        overrun,
    output logic        frame_err
);

`ifdef UART_DEV_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- host strobe edge detect ----------------
    logic rdn_q, wrn_q;
    logic rd_rise, wr_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_q <= 1'b1;
            wrn_q <= 1'b1;
        end else begin
            rdn_q <= rdn;
            wrn_q <= wrn;
        end
    end

    assign rd_rise = ~rdn_q & rdn;

    // ---------------- transmitter ----------------
    tx_state_t   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  thr_q, tsr_q;
    logic        tbre_q, tsre_q, txd_q;
    logic        tx_end;

    // A write while a read strobe is low is treated as bus contention and dropped.
    assign wr_take = ~wrn_q & wrn & rdn & tbre_q;
    assign tx_end  = (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            thr_q      <= '0;
            tsr_q      <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
        end else begin
            // Line level is registered from the state, so every bit is shifted one
            // cycle after the state that owns it but keeps its full length.
            txd_q <= (tx_state_q == TX_START) ? 1'b0 :
                     (tx_state_q == TX_DATA)  ? tsr_q[0] : 1'b1;
            if (wr_take) begin
                thr_q  <= data[7:0];
                tbre_q <= 1'b0;
            end
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tbre_q) begin
                        tsr_q      <= thr_q;
                        tbre_q     <= 1'b1;
                        tsre_q     <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_end) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_end) begin
                        tx_cnt_q <= '0;
                        tsr_q    <= {1'b0, tsr_q[7:1]};
                        if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
                        else                  tx_bit_q   <= tx_bit_q + 3'd1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: begin // TX_STOP
                    if (tx_end) begin
                        tx_cnt_q <= '0;
                        if (!tbre_q) begin
                            // Back-to-back frame: reload without an idle bit.
                            tsr_q      <= thr_q;
                            tbre_q     <= 1'b1;
                            tx_state_q <= TX_START;
                        end else begin
                            tsre_q     <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sr_q;
    logic        frame_err_q;
    logic        rx_push;

    assign rx_push = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sr_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            // rx_s3_q only feeds the start-edge detector; rx_s2_q is the sampled line.
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sr_q  <= {rx_s2_q, rx_sr_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: begin // RX_STOP
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        if (!rx_s2_q) frame_err_q <= 1'b1;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX storage ----------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]    st_cnt_q, st_cnt_d;
    logic          data_ready_q, overrun_q;
    logic          pop, full, push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop     = rd_rise & data_ready_q;
    assign full    = (st_cnt_q == 3'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full store still lands.
    assign push_ok = rx_push & (~full | pop);

    always_comb begin
        st_cnt_d = st_cnt_q;
        if (push_ok && !pop)      st_cnt_d = st_cnt_q + 3'd1;
        else if (pop && !push_ok) st_cnt_d = st_cnt_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_sr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            st_cnt_q     <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
            st_cnt_q     <= st_cnt_d;
            data_ready_q <= (st_cnt_d != 3'd0);
            if (rx_push && full && !pop) overrun_q <= 1'b1;
        end
    end

    // Upper bus bits carry no write data.
    logic unused_data_hi;
    assign unused_data_hi = ^data[15:8];

    assign data       = (rst && !rdn) ? {8'h00, mem_q[rd_ptr_q]} : {16{1'bz}};
    assign data_ready = data_ready_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/uart_dev.md
UART_DEV -- requirements
Module: uart_dev

Interface
REQ-001 SHALL have one parameter: CLKS_PER_BIT, 96, serial bit period in clk cycles, legal range 4..65535.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rst.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 data  inout  16  host bus; driven as {8'h00, rx byte} only while rdn=0, else high-Z.
REQ-006 rdn  input  1  host read strobe, active-low; the byte is popped on its rising edge.
REQ-007 wrn  input  1  host write strobe, active-low; data[7:0] is latched on its rising edge.
REQ-008 data_ready  output  1  1 = at least one received byte is pending.
REQ-009 tbre  output  1  1 = transmit holding register is empty.
REQ-010 tsre  output  1  1 = transmit shift register is idle.
REQ-011 rxd  input  1  serial in, asynchronous to clk.
REQ-012 txd  output  1  serial out; idles at 1.
REQ-013 overrun  output  1  sticky flag: a received byte was dropped because storage was full.
REQ-014 frame_err  output  1  sticky flag: a stop bit was sampled as 0.

Function
REQ-015 Edge detect SHALL register rdn and wrn each cycle; a rising edge is registered=0 and current=1.
REQ-016 A wrn rising edge with tbre=1 SHALL latch data[7:0] into THR and clear tbre on the next cycle.
REQ-017 A wrn rising edge with tbre=0, or while rdn=0, SHALL be ignored.
REQ-018 The TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA, TX_STOP, each bit lasting exactly CLKS_PER_BIT cycles.
- Frame: start bit 0, then 8 data bits LSB first, then 1 stop bit of 1.
REQ-019 In TX_IDLE with tbre=0, the FSM SHALL move THR to TSR and set tbre=1 and tsre=0 in the same cycle.
- txd SHALL go 0 on the following cycle.
REQ-020 At the end of TX_STOP, the FSM SHALL reload immediately (no idle gap) if tbre=0; otherwise it SHALL set tsre=1 and return to TX_IDLE.
REQ-021 rxd SHALL pass through a 2-FF synchronizer before use.
REQ-022 The RX FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP.
- A 1->0 transition in RX_IDLE SHALL enter RX_START.
- At CLKS_PER_BIT/2 (integer division), a 1 SHALL abort back to RX_IDLE (glitch); a 0 SHALL proceed.
- Each data bit and the stop bit SHALL be sampled at mid-bit, one CLKS_PER_BIT after the previous sample.
REQ-023 A stop bit sampled as 1 SHALL push the byte into RX storage.
REQ-024 A stop bit sampled as 0 SHALL discard the byte and set frame_err.
REQ-025 data_ready SHALL equal "RX storage not empty" and SHALL be registered.
REQ-026 A rdn rising edge with data_ready=1 SHALL pop one byte; a rdn rising edge with data_ready=0 SHALL do nothing.
REQ-027 A push into full storage SHALL drop the new byte and set overrun, unless a pop occurs in the same cycle.
- With a simultaneous pop, both the pop and the push SHALL complete.
REQ-028 Pointers SHALL wrap modulo the storage depth.

Reset
REQ-029 When rst=0, the block SHALL asynchronously force:
- txd=1, tbre=1, tsre=1, data_ready=0, overrun=0, frame_err=0;
- data high-Z;
- both FSMs to their IDLE states, and all pointers and bit counters to 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no partial byte stored or sent.
- After release, TX SHALL be idle and RX SHALL require a new start edge.

Configuration
REQ-031 With UART_DEV_RX_FIFO_EN defined, RX storage SHALL be a 4-entry FIFO.
REQ-032 With UART_DEV_RX_FIFO_EN undefined, RX storage SHALL be a single holding register.
- "Full" then means data_ready=1.
- All other behaviour SHALL be identical in both configurations.

Verification
REQ-033 CLKS_PER_BIT=8; write 8'hA5 via a wrn pulse -> tbre falls, then rises when the byte moves to TSR.
- txd = 0,1,0,1,0,0,1,0,1,1 over 80 cycles, then tsre=1.
REQ-034 Write 8'h11, then 8'h22 while the first is shifting -> the second frame starts directly after the stop bit; a third write while tbre=0 is ignored.
REQ-035 Drive a serial 8'h3C on rxd -> data_ready=1; rdn low shows data=16'h003C; after the rdn rise, data_ready=0.
REQ-036 Drive a 3-cycle rxd low glitch -> no byte stored, frame_err=0.
- Drive a frame with stop bit 0 -> frame_err=1, data_ready=0.
REQ-037 Receive 5 bytes with no reads -> FIFO build holds the first 4 and sets overrun=1; single-register build holds the first byte.
REQ-038 Assert rst mid-TX and mid-RX -> txd=1, tbre=tsre=1, data_ready=0 immediately; a normal transfer succeeds after release.
